// File: rtl/acis_stream_pkg.sv
// Shared stream types and datapath constants for the ACIS egress slice.
package acis_stream_pkg;
   localparam int unsigned PHIT_W = 512;
   localparam int unsigned DP_LAT = 16;

   typedef logic [PHIT_W-1:0] phit_t;
endpackage

// File: rtl/stream_egress_if.sv
// Backpressured output stream with packet framing.
interface stream_egress_if import acis_stream_pkg::*; #(
   parameter int unsigned W = PHIT_W
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word fall-through FIFO; head entry is visible without a read strobe.
module sync_fifo_fwft #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      empty    = (count == '0);
      full     = (count == CNT_W'(DEPTH));
      do_push  = push && !full;
      do_pop   = pop && !empty;
      // Zero when empty so the stream data reads as 0 out of reset.
      pop_data = empty ? '0 : mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/stream_egress.sv
// Egress collector: tags valid phits through the datapath latency, buffers them,
// frames them into packets and returns injection credit to the scheduler.
module stream_egress import acis_stream_pkg::*; #(
   parameter int unsigned PHIT      = PHIT_W,
   parameter int unsigned LAT       = DP_LAT,
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned PKT_PHITS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              issue_ok,
   input  logic [PHIT-1:0]   dp_stream_out,
   stream_egress_if.master   m,
   output logic              err_overflow
);
   localparam int unsigned INF_W  = $clog2(LAT+1);
   localparam int unsigned SUM_W  = $clog2(DEPTH+LAT+1);
   localparam int unsigned CNT_W  = $clog2(DEPTH+1);
   localparam int unsigned BEAT_W = (PKT_PHITS > 1) ? $clog2(PKT_PHITS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_PHITS-1);

   logic [LAT-1:0]    vld_sr;
   logic [LAT-1:0]    head_vec;
   logic [INF_W-1:0]  inflight;
   logic [CNT_W-1:0]  fifo_count;
   logic [BEAT_W-1:0] beat;
   logic [PHIT-1:0]   head_data;
   logic              accept;
   logic              tail;
   logic              pop;
   logic              fifo_empty;
   logic              fifo_full;

   // Credit covers both buffered and still-in-pipeline phits, so a tagged tail always finds room.
   always_comb begin
      issue_ok    = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(DEPTH);
      accept      = in_valid && issue_ok;
      tail        = vld_sr[LAT-1];
      head_vec    = '0;
      head_vec[0] = accept;
      pop         = !fifo_empty && m.tready;
   end

   always_comb begin
      m.tvalid = !fifo_empty;
      m.tdata  = head_data;
      m.tlast  = !fifo_empty && (beat == LAST_BEAT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_sr       <= '0;
         inflight     <= '0;
         beat         <= '0;
         err_overflow <= 1'b0;
      end else begin
         vld_sr <= (vld_sr << 1) | head_vec;
         case ({accept, tail})
            2'b10:   inflight <= inflight + INF_W'(1);
            2'b01:   inflight <= inflight - INF_W'(1);
            default: ;
         endcase
         if (in_valid && !issue_ok) err_overflow <= 1'b1;
         if (pop) beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
      end
   end

   sync_fifo_fwft #(
      .WIDTH (PHIT),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tail),
      .push_data (dp_stream_out),
      .pop       (pop),
      .pop_data  (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(tail && fifo_full));
endmodule
